// File: rtl/bw_r_irf_pkg.sv
// Shared constants and encodings for the register-file window controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bw_r_irf_pkg;

   localparam int NTHR = 4;
   localparam int NWIN = 8;

   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_SAVE = 2'b01,
      OP_REST = 2'b10,
      OP_SWAP = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SAVE  = 3'd1,
      ST_REST  = 3'd2,
      ST_STALL = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

endpackage

// File: rtl/bw_r_irf_rr_arb.sv
// 4-way round-robin arbiter: lowest index at or after ptr (wrapping) wins.
// Latency: combinational.
// Backpressure: none; caller decides whether to use the grant.
module bw_r_irf_rr_arb
   import bw_r_irf_pkg::*;
(
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [3:0] gnt,
   output logic       vld
);

   logic [1:0] idx;

   // Scan the four positions starting at ptr; the first requester found wins.
   always_comb begin
      gnt = '0;
      vld = 1'b0;
      idx = '0;
      for (int k = 0; k < 4; k++) begin
         idx = ptr + 2'(k);
         if (!vld && req[idx]) begin
            gnt[idx] = 1'b1;
            vld      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bw_r_irf_win_ctl.sv
// Register-window save/restore sequencer: grants one thread at a time and strobes the array.
// Latency: grant->done 2 cycles (save/restore), 3 (swap), 4 (swap to the same window).
// Backpressure: hold blocks new grants only; requests are held until done.
module bw_r_irf_win_ctl
   import bw_r_irf_pkg::*;
#(
   parameter int NTHR = bw_r_irf_pkg::NTHR,
   parameter int NWIN = bw_r_irf_pkg::NWIN
) (
   input  logic                          clk,
   input  logic                          rst_l,
   input  logic [NTHR-1:0]               req_vld,
   input  logic [2*NTHR-1:0]             req_op,
   input  logic [$clog2(NWIN)*NTHR-1:0]  req_swin,
   input  logic [$clog2(NWIN)*NTHR-1:0]  req_rwin,
   input  logic                          hold,
   output logic [NTHR-1:0]               grant,
   output logic [NTHR-1:0]               done,
   output logic                          save,
   output logic [4:0]                    save_addr,
   output logic                          restore,
   output logic [4:0]                    restore_addr,
   output logic                          busy
);

   localparam int TW = $clog2(NTHR);
   localparam int WW = $clog2(NWIN);

   state_e          state_q, state_d;
   op_e             op_q, op_d;
   logic [TW-1:0]   thr_q, thr_d;
   logic [TW-1:0]   rr_q, rr_d;
   logic [WW-1:0]   swin_q, swin_d;
   logic [WW-1:0]   rwin_q, rwin_d;
   logic            save_q, save_d;
   logic            restore_q, restore_d;
   logic [4:0]      save_addr_q, save_addr_d;
   logic [4:0]      restore_addr_q, restore_addr_d;

   logic [NTHR-1:0] elig;
   logic [NTHR-1:0] arb_gnt;
   logic            arb_vld;
   logic [TW-1:0]   gthr;
   op_e             gop;
   logic [WW-1:0]   gswin;
   logic [WW-1:0]   grwin;

   // A thread is eligible only if it requests a real operation.
   always_comb begin
      elig = '0;
      for (int t = 0; t < NTHR; t++) begin
         elig[t] = req_vld[t] & (|req_op[2*t +: 2]);
      end
   end

   bw_r_irf_rr_arb u_arb (
      .req (elig),
      .ptr (rr_q),
      .gnt (arb_gnt),
      .vld (arb_vld)
   );

   // Decode the winning thread and pick up its command fields.
   always_comb begin
      gthr = '0;
      for (int t = 0; t < NTHR; t++) begin
         if (arb_gnt[t]) gthr = TW'(t);
      end
      gop   = op_e'(req_op[2*int'(gthr) +: 2]);
      gswin = req_swin[WW*int'(gthr) +: WW];
      grwin = req_rwin[WW*int'(gthr) +: WW];
   end

   // Sequencer next state; strobes are computed one cycle ahead so they come out of flops.
   always_comb begin
      state_d        = state_q;
      op_d           = op_q;
      thr_d          = thr_q;
      rr_d           = rr_q;
      swin_d         = swin_q;
      rwin_d         = rwin_q;
      save_d         = 1'b0;
      restore_d      = 1'b0;
      save_addr_d    = save_addr_q;
      restore_addr_d = restore_addr_q;
      grant          = '0;
      case (state_q)
         ST_IDLE: begin
            if (rst_l && !hold && arb_vld) begin
               grant  = arb_gnt;
               thr_d  = gthr;
               op_d   = gop;
               swin_d = gswin;
               rwin_d = grwin;
               rr_d   = gthr + TW'(1);
               if (gop == OP_REST) begin
                  state_d        = ST_REST;
                  restore_d      = 1'b1;
                  restore_addr_d = {gthr, grwin};
               end else begin
                  state_d     = ST_SAVE;
                  save_d      = 1'b1;
                  save_addr_d = {gthr, gswin};
               end
            end
         end
         ST_SAVE: begin
            if (op_q == OP_SAVE) begin
               state_d = ST_DONE;
            end else if (swin_q == rwin_q) begin
               // Same window: let the save write land before restoring it.
               state_d = ST_STALL;
            end else begin
               state_d        = ST_REST;
               restore_d      = 1'b1;
               restore_addr_d = {thr_q, rwin_q};
            end
         end
         ST_STALL: begin
            state_d        = ST_REST;
            restore_d      = 1'b1;
            restore_addr_d = {thr_q, rwin_q};
         end
         ST_REST: state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State register; reset drops any in-flight operation silently.
   always_ff @(posedge clk) begin
      if (!rst_l) begin
         state_q        <= ST_IDLE;
         op_q           <= OP_NONE;
         thr_q          <= '0;
         rr_q           <= '0;
         swin_q         <= '0;
         rwin_q         <= '0;
         save_q         <= 1'b0;
         restore_q      <= 1'b0;
         save_addr_q    <= '0;
         restore_addr_q <= '0;
      end else begin
         state_q        <= state_d;
         op_q           <= op_d;
         thr_q          <= thr_d;
         rr_q           <= rr_d;
         swin_q         <= swin_d;
         rwin_q         <= rwin_d;
         save_q         <= save_d;
         restore_q      <= restore_d;
         save_addr_q    <= save_addr_d;
         restore_addr_q <= restore_addr_d;
      end
   end

   // Completion pulse is a pure decode of the DONE state.
   always_comb begin
      done = '0;
      if (state_q == ST_DONE) done[thr_q] = 1'b1;
   end

   assign save         = save_q;
   assign save_addr    = save_addr_q;
   assign restore      = restore_q;
   assign restore_addr = restore_addr_q;
   assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bw_r_irf_win_ctl.sv
// Bench for bw_r_irf_win_ctl: directed vectors plus a cycle-by-cycle schedule model.
module tb_bw_r_irf_win_ctl;

   logic        clk = 1'b0;
   logic        rst_l;
   logic [3:0]  req_vld;
   logic [7:0]  req_op;
   logic [11:0] req_swin;
   logic [11:0] req_rwin;
   logic        hold;
   logic [3:0]  grant;
   logic [3:0]  done;
   logic        save;
   logic [4:0]  save_addr;
   logic        restore;
   logic [4:0]  restore_addr;
   logic        busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bw_r_irf_win_ctl dut (
      .clk          (clk),
      .rst_l        (rst_l),
      .req_vld      (req_vld),
      .req_op       (req_op),
      .req_swin     (req_swin),
      .req_rwin     (req_rwin),
      .hold         (hold),
      .grant        (grant),
      .done         (done),
      .save         (save),
      .save_addr    (save_addr),
      .restore      (restore),
      .restore_addr (restore_addr),
      .busy         (busy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- schedule model ----------------
   // Each granted operation expands into a list of per-cycle output expectations.
   typedef struct packed {
      logic       sv;
      logic [4:0] sa;
      logic       rs;
      logic [4:0] ra;
      logic [3:0] dn;
   } ent_t;

   ent_t       mq[$];
   ent_t       me;
   int         m_rr = 0;
   logic [4:0] m_lsa = '0;
   logic [4:0] m_lra = '0;
   logic       m_valid = 1'b0;
   logic [3:0] m_gnt;
   logic       m_busy;
   int         m_pick;
   int         m_t;
   logic [1:0] m_op;
   logic [2:0] m_sw, m_rw;

   always @(negedge clk) begin
      if (m_valid) begin
         m_gnt  = '0;
         m_pick = -1;
         if (mq.size() > 0) begin
            me     = mq.pop_front();
            m_busy = 1'b1;
         end else begin
            me     = '0;
            m_busy = 1'b0;
            if (rst_l && !hold) begin
               for (int k = 0; k < 4; k++) begin
                  m_t = (m_rr + k) % 4;
                  if (m_pick < 0 && req_vld[m_t] && req_op[2*m_t +: 2] != 2'b00) m_pick = m_t;
               end
            end
         end
         if (me.sv) m_lsa = me.sa;
         if (me.rs) m_lra = me.ra;
         if (m_pick >= 0) m_gnt[m_pick] = 1'b1;
         chk("m_grant", grant, m_gnt);
         chk("m_done", done, me.dn);
         chk("m_save", save, me.sv);
         chk("m_restore", restore, me.rs);
         chk("m_save_addr", save_addr, m_lsa);
         chk("m_restore_addr", restore_addr, m_lra);
         chk("m_busy", busy, m_busy);
         if (m_pick >= 0) begin
            m_op = req_op[2*m_pick +: 2];
            m_sw = req_swin[3*m_pick +: 3];
            m_rw = req_rwin[3*m_pick +: 3];
            m_rr = (m_pick + 1) % 4;
            if (m_op != 2'b10) mq.push_back('{1'b1, {2'(m_pick), m_sw}, 1'b0, 5'h0, 4'h0});
            if (m_op == 2'b11 && m_sw == m_rw) mq.push_back('0);
            if (m_op != 2'b01) mq.push_back('{1'b0, 5'h0, 1'b1, {2'(m_pick), m_rw}, 4'h0});
            mq.push_back('{1'b0, 5'h0, 1'b0, 5'h0, 4'(1 << m_pick)});
         end
      end
      if (!rst_l) begin
         mq.delete();
         m_rr    = 0;
         m_lsa   = '0;
         m_lra   = '0;
         m_valid = 1'b1;
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setreq(input int t, input logic [1:0] op, input logic [2:0] sw, input logic [2:0] rw);
      req_vld[t]         = 1'b1;
      req_op[2*t +: 2]   = op;
      req_swin[3*t +: 3] = sw;
      req_rwin[3*t +: 3] = rw;
   endtask

   task automatic clrreq(input int t);
      req_vld[t]       = 1'b0;
      req_op[2*t +: 2] = 2'b00;
   endtask

   logic [3:0] g_seen [5];
   int         g_cyc  [5];
   int         ng;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_l = 1'b0; req_vld = '0; req_op = '0; req_swin = '0; req_rwin = '0; hold = 1'b0;
      tick(); tick();
      @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_grant", grant, 4'h0);
      chk("rst_save_addr", save_addr, 5'h00);
      chk("rst_restore_addr", restore_addr, 5'h00);
      tick();
      rst_l = 1'b1;

      // save only, thread 2, window 5
      setreq(2, 2'b01, 3'd5, 3'd0);
      @(negedge clk); chk("save_grant", grant, 4'b0100);
      tick(); @(negedge clk);
      chk("save_strobe", save, 1'b1);
      chk("save_addr", save_addr, 5'b10101);
      tick(); @(negedge clk); chk("save_done", done, 4'b0100);
      tick(); clrreq(2);

      // swap without stall, thread 1, 3 -> 4
      setreq(1, 2'b11, 3'd3, 3'd4);
      @(negedge clk); chk("swap_grant", grant, 4'b0010);
      tick(); @(negedge clk); chk("swap_save_addr", save_addr, 5'h0B);
      tick(); @(negedge clk);
      chk("swap_restore", restore, 1'b1);
      chk("swap_restore_addr", restore_addr, 5'h0C);
      chk("swap_addr_held", save_addr, 5'h0B);
      tick(); @(negedge clk); chk("swap_done", done, 4'b0010);
      tick(); clrreq(1);

      // swap with stall, thread 0, 6 -> 6; request dropped right after grant
      setreq(0, 2'b11, 3'd6, 3'd6);
      @(negedge clk); chk("stall_grant", grant, 4'b0001);
      tick(); clrreq(0);
      @(negedge clk); chk("stall_save_addr", save_addr, 5'h06);
      tick(); @(negedge clk);
      chk("stall_idle", {save, restore, busy}, 3'b001);
      tick(); @(negedge clk); chk("stall_restore_addr", restore_addr, 5'h06);
      tick(); @(negedge clk); chk("stall_done", done, 4'b0001);
      tick();

      // hold blocks the grant
      hold = 1'b1;
      setreq(3, 2'b10, 3'd0, 3'd5);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); chk("hold_no_grant", grant, 4'h0);
         tick();
      end
      hold = 1'b0;
      @(negedge clk); chk("hold_release_grant", grant, 4'b1000);
      tick(); @(negedge clk); chk("hold_restore_addr", restore_addr, 5'h1D);
      tick(); @(negedge clk); chk("hold_done", done, 4'b1000);
      tick(); clrreq(3);

      // fairness from reset
      rst_l = 1'b0;
      tick();
      rst_l = 1'b1;
      for (int t = 0; t < 4; t++) setreq(t, 2'b10, 3'd0, 3'(t));
      ng = 0;
      for (int c = 0; c < 30 && ng < 5; c++) begin
         @(negedge clk);
         if (grant != 4'h0) begin
            g_seen[ng] = grant;
            g_cyc[ng]  = c;
            ng++;
         end
         tick();
      end
      chk("fair_count", ng, 5);
      chk("fair_g0", g_seen[0], 4'b0001);
      chk("fair_g1", g_seen[1], 4'b0010);
      chk("fair_g2", g_seen[2], 4'b0100);
      chk("fair_g3", g_seen[3], 4'b1000);
      chk("fair_g4", g_seen[4], 4'b0001);
      for (int i = 1; i < 5; i++) chk("fair_gap", g_cyc[i] - g_cyc[i-1], 3);

      // reset in the middle of a swap
      rst_l = 1'b0;
      tick();
      rst_l = 1'b1;
      for (int t = 0; t < 4; t++) setreq(t, 2'b11, 3'd1, 3'd2);
      @(negedge clk); chk("mid_grant", grant, 4'b0001);
      tick(); @(negedge clk); chk("mid_save", save, 1'b1);
      tick();
      rst_l = 1'b0;
      @(negedge clk); chk("mid_in_rest", restore, 1'b1);
      tick(); @(negedge clk);
      chk("mid_rst_outs", {grant, done, save, restore, busy}, 11'h0);
      chk("mid_rst_addrs", {save_addr, restore_addr}, 10'h0);
      tick();
      rst_l = 1'b1;
      @(negedge clk); chk("mid_first_grant", grant, 4'b0001);
      tick();
      for (int t = 0; t < 4; t++) clrreq(t);
      repeat (6) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bw_r_irf_win_ctl.md
BW_R_IRF_WIN_CTL -- requirements
Module: bw_r_irf_win_ctl

Interface
REQ-001 SHALL have parameter NTHR, default 4, number of hardware threads; the only supported value is 4.
REQ-002 SHALL have parameter NWIN, default 8, register windows per thread; the only supported value is 8.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_l, input, 1 bit, synchronous reset, active-low.
REQ-005 SHALL have port req_vld, input, 4 bits, per-thread window-operation request; held until the matching done.
REQ-006 SHALL have port req_op, input, 8 bits, 2 bits per thread: 01 save, 10 restore, 11 swap (save then restore), 00 ignored.
REQ-007 SHALL have port req_swin, input, 12 bits, 3 bits per thread, the window number to save.
REQ-008 SHALL have port req_rwin, input, 12 bits, 3 bits per thread, the window number to restore.
REQ-009 SHALL have port hold, input, 1 bit; when high, no new command is issued.
REQ-010 SHALL have port grant, output, 4 bits, one-hot, one-cycle pulse marking the accepted thread.
REQ-011 SHALL have port done, output, 4 bits, one-hot, one-cycle pulse marking completion of the thread's last command.
REQ-012 SHALL have port save, output, 1 bit, save strobe to the register-file array.
REQ-013 SHALL have port save_addr, output, 5 bits, {thread[1:0], window[2:0]}.
REQ-014 SHALL have port restore, output, 1 bit, restore strobe.
REQ-015 SHALL have port restore_addr, output, 5 bits, {thread[1:0], window[2:0]}.
REQ-016 SHALL have port busy, output, 1 bit, high whenever the FSM is not in IDLE.

Function
REQ-017 SHALL implement the FSM states IDLE, SAVE, REST, STALL and DONE.
REQ-018 SHALL, in IDLE with hold low, pick the next thread with req_vld set and req_op not 00, searching round-robin from rr_ptr; it SHALL pulse grant for that thread and latch its thread number, op and windows.
REQ-019 SHALL move rr_ptr to the granted thread plus 1, modulo 4, on each grant.
REQ-020 SHALL leave IDLE for SAVE when the op is 01 or 11, and for REST when the op is 10.
REQ-021 SHALL drive save and save_addr from flops, high for exactly one cycle in SAVE. Op 01 then goes to DONE. Op 11 goes to STALL when the saved address equals the restore address, else to REST.
REQ-022 SHALL remain in STALL for exactly one cycle, outputs idle, then go to REST; this stall lets the save write complete before the same address is restored.
REQ-023 SHALL drive restore and restore_addr from flops, high for exactly one cycle in REST, then go to DONE.
REQ-024 SHALL pulse done for the latched thread in DONE and then return to IDLE; grant therefore never occurs in the DONE cycle.
REQ-025 SHALL hold save_addr and restore_addr at their last values while the strobes are low.
REQ-026 SHALL give the following latency from grant to done: op 01 and op 10 take 2 cycles; op 11 takes 3 cycles, or 4 cycles with a stall.
REQ-027 SHALL let hold block only the IDLE grant; an operation already granted runs to completion regardless of hold.
REQ-028 SHALL ignore a req_vld drop after grant; the latched operation completes and done is still pulsed.
REQ-029 SHALL never assert save and restore in the same cycle.

Reset
REQ-030 SHALL, on a clk edge with rst_l low, set the state to IDLE and rr_ptr to 0.
REQ-031 SHALL set grant, done, save and restore to 0 and save_addr and restore_addr to 5'h00 on that edge.
REQ-032 SHALL abort any in-flight operation on reset with no done pulse; requesters re-request afterwards.

Structure
REQ-033 SHALL place the op encodings (SAVE, REST, SWAP), the FSM state encoding, and the NTHR and NWIN constants in a shared package, bw_r_irf_pkg.
REQ-034 SHALL use one sub-module, bw_r_irf_rr_arb: a 4-way round-robin arbiter taking req[3:0] and ptr[1:0] and returning a one-hot gnt and a valid flag.

Verification
REQ-035 SHALL cover a save-only request: thread 2 requests op 01 with swin 5 -> grant 4'b0100, next cycle save=1 with save_addr 5'b10101, next cycle done 4'b0100.
REQ-036 SHALL cover a swap without a stall: thread 1 requests op 11 with swin 3 and rwin 4 -> save_addr 5'h0B, then restore_addr 5'h0C on the next cycle, then done.
REQ-037 SHALL cover a swap with a stall: thread 0 requests op 11 with swin 6 and rwin 6 -> save of 5'h06, one idle cycle, restore of 5'h06, done 4 cycles after grant.
REQ-038 SHALL cover fairness: all 4 threads request op 10 continuously from reset -> grants in the order 0, 1, 2, 3, 0, and each grant is 3 cycles after the previous one.
REQ-039 SHALL cover hold: hold=1 with requests pending -> no grant; release hold -> grant on the next IDLE cycle.
REQ-040 SHALL cover reset mid-operation: rst_l=0 during REST of a swap -> all outputs 0 on the next cycle, no done pulse, and after release the first grant goes to thread 0.
